// File: rtl/permutation_sequencer_pkg.sv
// Shared Ascon definitions: 320-bit state layout, round-count constants,
// sequencer FSM encoding and the round helpers used by the datapath.
package ascon_pack;

  // Word xN of the Ascon state lives at index N.
  typedef logic [4:0][63:0] type_state;

  localparam logic [3:0] ROUNDS_A   = 4'd12;
  localparam logic [3:0] ROUNDS_B   = 4'd6;
  localparam logic [3:0] ROUND_LAST = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } type_fsm;

  function automatic logic [63:0] rotr64(input logic [63:0] w, input int unsigned n);
    return (w >> n) | (w << (64 - n));
  endfunction

  // Round i uses the byte {15-i, i}; i never exceeds ROUND_LAST.
  function automatic logic [7:0] round_constant(input logic [3:0] i);
    return {4'd15 - i, i};
  endfunction

endpackage

// File: rtl/permutation_sequencer_permutation.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
// Latency 0 cycles; no flow control, output follows inputs.
module permutation
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  type_state   state_add;
  type_state   state_sub;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;

  always_comb begin : constant_addition
    state_add       = state_i;
    state_add[2]    = state_i[2] ^ {56'd0, round_constant(round_i)};
  end

  // Bit-sliced form of the Ascon S-box, applied to all 64 columns at once.
  always_comb begin : substitution_layer
    a0 = state_add[0] ^ state_add[4];
    a1 = state_add[1];
    a2 = state_add[2] ^ state_add[1];
    a3 = state_add[3];
    a4 = state_add[4] ^ state_add[3];

    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;

    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;

    state_sub[0] = b0 ^ b4;
    state_sub[1] = b1 ^ b0;
    state_sub[2] = ~b2;
    state_sub[3] = b3 ^ b2;
    state_sub[4] = b4;
  end

  always_comb begin : diffusion_layer
    state_o[0] = state_sub[0] ^ rotr64(state_sub[0], 19) ^ rotr64(state_sub[0], 28);
    state_o[1] = state_sub[1] ^ rotr64(state_sub[1], 61) ^ rotr64(state_sub[1], 39);
    state_o[2] = state_sub[2] ^ rotr64(state_sub[2],  1) ^ rotr64(state_sub[2],  6);
    state_o[3] = state_sub[3] ^ rotr64(state_sub[3], 10) ^ rotr64(state_sub[3], 17);
    state_o[4] = state_sub[4] ^ rotr64(state_sub[4],  7) ^ rotr64(state_sub[4], 41);
  end

endmodule

// File: rtl/permutation_sequencer.sv
// Iterates the Ascon round N times (N = 12, or nb_rounds_i when 1..12) over a loaded state.
// Latency N cycles from start to done pulse; start_i is ignored while busy, no other backpressure.
module permutation_sequencer
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] nb_rounds_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  type_fsm    fsm_q;
  type_fsm    fsm_d;
  logic [3:0] cnt_q;
  logic [3:0] first_round;
  logic       load;
  type_state  state_q;
  type_state  round_out;

  // Out-of-range requests fall back to the full p^a schedule.
  always_comb begin
    first_round = 4'd0;
    if (nb_rounds_i != 4'd0 && nb_rounds_i <= ROUNDS_A) begin
      first_round = ROUNDS_A - nb_rounds_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    load  = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (start_i) begin
          load  = 1'b1;
          fsm_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == ROUND_LAST) begin
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start_i) begin
          load  = 1'b1;
          fsm_d = ST_RUN;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Counter parks at ROUND_LAST once the final round is issued.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= 4'd0;
      state_q <= '0;
    end else if (load) begin
      cnt_q   <= first_round;
      state_q <= state_i;
    end else if (fsm_q == ST_RUN) begin
      state_q <= round_out;
      if (cnt_q != ROUND_LAST) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  permutation u_permutation (
    .state_i (state_q),
    .round_i (round_o),
    .state_o (round_out)
  );

  assign state_o = state_q;
  assign round_o = (fsm_q == ST_RUN) ? cnt_q : 4'd0;
  assign busy_o  = (fsm_q == ST_RUN);
  assign done_o  = (fsm_q == ST_DONE);

endmodule
